// File: rtl/i2s_rx_if.sv
// Purpose: bundles the I2S receiver's serial inputs and its stereo-pair output port.
// Latency: none (wiring only).
// Backpressure: out_valid/out_ready; the receiver side drives out_valid, the sink drives out_ready.
interface i2s_rx_if #(
    parameter int AUDIO_DW = 32
);
    logic                lrclk;
    logic                sdata;
    logic [AUDIO_DW-1:0] left_chan;
    logic [AUDIO_DW-1:0] right_chan;
    logic                out_valid;
    logic                out_ready;
    logic                locked;
    logic                frame_err;
    logic                overrun;

    // Receiver side: consumes the serial stream, produces stereo pairs and status.
    modport master (
        input  lrclk,
        input  sdata,
        input  out_ready,
        output left_chan,
        output right_chan,
        output out_valid,
        output locked,
        output frame_err,
        output overrun
    );

    // Environment side: drives the serial stream and accepts stereo pairs.
    modport slave (
        output lrclk,
        output sdata,
        output out_ready,
        input  left_chan,
        input  right_chan,
        input  out_valid,
        input  locked,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/i2s_rx.sv
// Purpose: I2S deserializer; rebuilds MSB-first left/right words and emits stereo pairs.
// Latency: pair registered on the right-word LSB edge, visible one sclk later.
// Backpressure: held pair stays stable while !out_ready; a pair finishing meanwhile is dropped and flagged as overrun.
module i2s_rx #(
    parameter int AUDIO_DW = 32
) (
    input  logic     i_sclk,
    input  logic     i_rst,
    i2s_rx_if.master bus
);

    localparam int CNT_W = $clog2(AUDIO_DW + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(AUDIO_DW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUDIO_DW - 1);

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        RX_LEFT  = 2'd1,
        RX_RIGHT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_lr_q;
    logic [AUDIO_DW-1:0] r_shift;
    logic [CNT_W-1:0]    r_cnt;
    logic [AUDIO_DW-1:0] r_left_hold;

    logic [AUDIO_DW-1:0] r_left_chan;
    logic [AUDIO_DW-1:0] r_right_chan;
    logic                r_out_valid;
    logic                r_frame_err;
    logic                r_overrun;

    logic                w_edge;
    logic [AUDIO_DW-1:0] w_word;
    logic                w_len_ok;
    logic                w_load_left;
    logic                w_complete;
    logic                w_frame_err;
    logic                w_can_load;

    // Any change of lrclk closes the word of the previous channel; the bit sampled
    // on that same sclk is the closing word's LSB (one-bit I2S delay).
    assign w_edge   = (bus.lrclk != r_lr_q);
    assign w_word   = {r_shift[AUDIO_DW-2:0], bus.sdata};
    // Glitched (short) and over-long (saturated counter) words both fail this test.
    assign w_len_ok = (r_cnt == CNT_LAST);

    // A finished pair may be loaded if the output slot is empty or is being
    // emptied in this very cycle.
    assign w_can_load = !r_out_valid || bus.out_ready;

    // Serial capture: word-select history, shift register and bit counter.
    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            r_lr_q  <= 1'b1;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_lr_q  <= bus.lrclk;
            r_shift <= w_word;
            if (w_edge) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_SAT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and per-edge actions. Edges strictly alternate direction, so in
    // RX_LEFT an edge is always 0->1 and in RX_RIGHT always 1->0.
    always_comb begin
        w_state_nxt = r_state;
        w_load_left = 1'b0;
        w_complete  = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            HUNT: begin
                // Only a 1->0 edge starts a left word; errors are not reported here.
                if (w_edge && !bus.lrclk) begin
                    w_state_nxt = RX_LEFT;
                end
            end
            RX_LEFT: begin
                if (w_edge) begin
                    if (w_len_ok) begin
                        w_load_left = 1'b1;
                        w_state_nxt = RX_RIGHT;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_nxt = HUNT;
                    end
                end
            end
            RX_RIGHT: begin
                // The 1->0 edge that closes the right word also opens the next left
                // word, so lock is kept even when the right word was bad.
                if (w_edge) begin
                    w_state_nxt = RX_LEFT;
                    if (w_len_ok) begin
                        w_complete = 1'b1;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = HUNT;
            end
        endcase
    end

    // Left word is parked here until its right partner arrives.
    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            r_left_hold <= '0;
        end else if (w_load_left) begin
            r_left_hold <= w_word;
        end
    end

    // Output slot: load a completed pair, drop it on overrun, or retire on handshake.
    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            r_left_chan  <= '0;
            r_right_chan <= '0;
            r_out_valid  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_complete) begin
                if (w_can_load) begin
                    r_left_chan  <= r_left_hold;
                    r_right_chan <= w_word;
                    r_out_valid  <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Framing error pulse, aligned with the other registered outputs.
    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
        end
    end

    assign bus.left_chan  = r_left_chan;
    assign bus.right_chan = r_right_chan;
    assign bus.out_valid  = r_out_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;
    assign bus.locked     = (r_state == RX_LEFT) || (r_state == RX_RIGHT);

endmodule

// File: tb/tb_i2s_rx.sv
// Purpose: directed bench for i2s_rx with a serial I2S source model and a pair scoreboard.
// Latency: pairs are scored when the receiver first presents them.
// Backpressure: out_ready is driven per step to exercise hold, overrun and same-cycle reload.
module tb_i2s_rx;

    localparam int DW = 32;

    logic sclk = 1'b0;
    logic rst  = 1'b1;

    i2s_rx_if #(.AUDIO_DW(DW)) bus ();

    i2s_rx #(.AUDIO_DW(DW)) dut (
        .i_sclk (sclk),
        .i_rst  (rst),
        .bus    (bus)
    );

    always #5 sclk = ~sclk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_ferr  = 0;
    int n_ovr   = 0;
    int n_pairs = 0;

    logic [63:0] sb[$];
    logic        pend = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One lrclk phase of len sclk. First bit is the previous word's LSB, then the
    // MSB-first bits of w; the bit left over becomes the next phase's first bit.
    task automatic phase(input logic lr, input logic [31:0] w, input int len, input int rdy = -1);
        for (int k = 0; k < len; k++) begin
            @(posedge sclk);
            #1;
            bus.lrclk = lr;
            if (k == 0) begin
                bus.sdata = pend;
                if (rdy >= 0) bus.out_ready = (rdy != 0);
            end else if (k - 1 < 32) begin
                bus.sdata = w[31 - (k - 1)];
            end else begin
                bus.sdata = 1'b0;
            end
        end
        pend = (len >= 1 && len <= 32) ? w[32 - len] : 1'b0;
    endtask

    task automatic frame(input logic [31:0] l, input logic [31:0] r, input bit push);
        phase(1'b0, l, 32);
        if (push) sb.push_back({l, r});
        phase(1'b1, r, 32);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_left"},  64'(bus.left_chan),  64'd0);
        chk({tag, "_right"}, 64'(bus.right_chan), 64'd0);
        chk({tag, "_valid"}, 64'(bus.out_valid),  64'd0);
        chk({tag, "_locked"},64'(bus.locked),     64'd0);
        chk({tag, "_ferr"},  64'(bus.frame_err),  64'd0);
        chk({tag, "_ovr"},   64'(bus.overrun),    64'd0);
    endtask

    // Output monitor: counts status pulses, scores newly presented pairs and checks
    // that a stalled pair stays put.
    initial begin
        logic            pv;
        logic            pr;
        logic [DW-1:0]   pl;
        logic [DW-1:0]   prr;
        logic [63:0]     exp;
        pv = 1'b0; pr = 1'b0; pl = '0; prr = '0;
        forever begin
            @(negedge sclk);
            if (rst) begin
                pv = 1'b0;
                pr = 1'b0;
            end else begin
                if (bus.out_valid) n_valid++;
                if (bus.frame_err) n_ferr++;
                if (bus.overrun)   n_ovr++;
                if (bus.out_valid && (!pv || pr)) begin
                    chk("pair_expected", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        exp = sb.pop_front();
                        n_pairs++;
                        chk("pair_left",  64'(bus.left_chan),  64'(exp[63:32]));
                        chk("pair_right", 64'(bus.right_chan), 64'(exp[31:0]));
                    end
                end else if (pv && !pr) begin
                    chk("hold_valid", 64'(bus.out_valid),  64'd1);
                    chk("hold_left",  64'(bus.left_chan),  64'(pl));
                    chk("hold_right", 64'(bus.right_chan), 64'(prr));
                end
                pv  = bus.out_valid;
                pr  = bus.out_ready;
                pl  = bus.left_chan;
                prr = bus.right_chan;
            end
        end
    end

    initial begin
        int v0;
        bus.lrclk     = 1'b1;
        bus.sdata     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge sclk);
        #1;
        chk_reset_outputs("rst0");
        rst = 1'b0;

        // 1: steady stream, ready always high
        phase(1'b1, 32'h0BAD_0BAD, 20);
        chk("t1_unlocked", 64'(bus.locked), 64'd0);
        frame(32'hA5A5_0001, 32'h8000_FFFF, 1'b1);
        chk("t1_locked", 64'(bus.locked), 64'd1);
        for (int i = 0; i < 3; i++) frame(32'hA5A5_0001, 32'h8000_FFFF, 1'b1);

        // 2: short left phase -> framing error, lock lost until next full frame
        phase(1'b0, 32'h1111_2222, 16);
        chk("t1_valid_cycles", 64'(n_valid), 64'd4);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);
        phase(1'b1, 32'h3333_4444, 32);
        chk("t2_ferr", 64'(n_ferr), 64'd1);
        chk("t2_unlocked", 64'(bus.locked), 64'd0);
        chk("t2_no_valid", 64'(n_valid), 64'd4);
        frame(32'h1234_5678, 32'hFEDC_BA98, 1'b1);

        // 3: stall for two frames -> first pair held, second overruns
        phase(1'b0, 32'h0F0F_F0F0, 32);
        v0 = n_valid;
        bus.out_ready = 1'b0;
        sb.push_back({32'h0F0F_F0F0, 32'h1357_9BDF});
        phase(1'b1, 32'h1357_9BDF, 32);
        frame(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
        phase(1'b0, 32'h0000_0001, 32);
        chk("t3_ovr", 64'(n_ovr), 64'd1);
        chk("t3_held_valid", 64'(bus.out_valid), 64'd1);
        chk("t3_held_left", 64'(bus.left_chan), 64'h0F0F_F0F0);
        chk("t3_held_right", 64'(bus.right_chan), 64'h1357_9BDF);
        bus.out_ready = 1'b1;
        sb.push_back({32'h0000_0001, 32'hFFFF_FFFE});
        phase(1'b1, 32'hFFFF_FFFE, 32);
        chk("t3_valid_cycles", 64'(n_valid - v0), 64'd95);
        chk("t3_valid_dropped", 64'(bus.out_valid), 64'd0);
        chk("t3_data_kept", 64'(bus.left_chan), 64'h0F0F_F0F0);

        // 4: ready rises in the exact completion cycle -> reload without overrun
        bus.out_ready = 1'b0;
        frame(32'h5555_AAAA, 32'hAAAA_5555, 1'b1);
        phase(1'b0, 32'h7777_0000, 32, 1);
        chk("t4_no_ovr", 64'(n_ovr), 64'd1);
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);

        // 5: reset asserted and released mid right word
        phase(1'b1, 32'h9999_9999, 10);
        rst = 1'b1;
        phase(1'b1, 32'h9999_9999, 3);
        chk_reset_outputs("t5_rst");
        rst = 1'b0;
        phase(1'b1, 32'h6666_6666, 12);
        frame(32'hC0DE_0001, 32'hC0DE_0002, 1'b1);
        frame(32'h0000_0000, 32'h7FFF_FFFF, 1'b1);

        // 6: reset pulsed mid left word -> outputs cleared, relock after fresh 1->0
        phase(1'b0, 32'h2468_ACE0, 10);
        chk("t5_no_ferr", 64'(n_ferr), 64'd1);
        rst = 1'b1;
        phase(1'b0, 32'h2468_ACE0, 1);
        chk_reset_outputs("t6_rst");
        rst = 1'b0;
        phase(1'b0, 32'h2468_ACE0, 21);
        phase(1'b1, 32'hBBBB_CCCC, 32);
        chk("t6_ferr", 64'(n_ferr), 64'd2);
        chk("t6_unlocked", 64'(bus.locked), 64'd0);
        frame($urandom, $urandom, 1'b1);
        chk("t6_relocked", 64'(bus.locked), 64'd1);
        frame($urandom, $urandom, 1'b1);
        phase(1'b0, 32'h0, 32);

        chk("end_sb_empty", 64'(sb.size()), 64'd0);
        chk("end_pairs", 64'(n_pairs), 64'd12);
        chk("end_ferr", 64'(n_ferr), 64'd2);
        chk("end_ovr", 64'(n_ovr), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
